// File: rtl/game2048_pkg.sv
// Shared state, direction and LFSR definitions for the 2048 game engine.
package game2048_pkg;

  typedef enum logic [2:0] {
    S_I     = 3'd0,
    S_WAIT  = 3'd1,
    S_MOVE  = 3'd2,
    S_SPAWN = 3'd3,
    S_CHECK = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Taps 16,14,13,11 of a left-shifting Fibonacci LFSR (bits 15,13,12,10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/game2048_line_merge.sv
// Combinational slide-and-merge of one board line toward element 0,
// with at most one merge per cell and the resulting score increment.
module game2048_line_merge #(
  parameter int N  = 4,
  parameter int EW = 4,
  localparam int IW = (1 << EW) + $clog2(N)
) (
  input  logic [N*EW-1:0] line_in,
  output logic [N*EW-1:0] line_out,
  output logic            changed,
  output logic [IW-1:0]   inc
);

  logic [EW-1:0] compact [N+1];
  logic [EW-1:0] merged  [N];

  always_comb begin
    int  k;
    logic skip;
    for (int i = 0; i <= N; i++) compact[i] = '0;
    for (int i = 0; i < N; i++) merged[i] = '0;
    inc  = '0;
    line_out = '0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (line_in[i*EW +: EW] != '0) begin
        compact[k] = line_in[i*EW +: EW];
        k = k + 1;
      end
    end
    // compact[N] stays zero so the last real cell never finds a partner
    k = 0;
    skip = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (compact[i] != '0 && compact[i] == compact[i+1]) begin
        merged[k] = compact[i] + EW'(1);
        inc = inc + (IW'(1) << ({1'b0, compact[i]} + (EW+1)'(1)));
        skip = 1'b1;
        k = k + 1;
      end else begin
        merged[k] = compact[i];
        k = k + 1;
      end
    end
    for (int i = 0; i < N; i++) line_out[i*EW +: EW] = merged[i];
    changed = (line_out != line_in);
  end

endmodule

// File: rtl/game2048_engine.sv
// N x N 2048 engine: one line per cycle moves, LFSR tile spawn,
// win/lose detection and a combinational tile read port.
module game2048_engine
  import game2048_pkg::*;
#(
  parameter int          N         = 4,
  parameter int          EW        = 4,
  parameter int          WIN_EXP   = 11,
  parameter int          SCORE_W   = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         AW        = $clog2(N)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_row,
  input  logic [AW-1:0]      wr_col,
  input  logic [EW-1:0]      wr_tile,
  input  logic [AW-1:0]      rd_row,
  input  logic [AW-1:0]      rd_col,
  output logic [EW-1:0]      rd_tile,
  output logic               q_I,
  output logic               q_Wait,
  output logic               q_Move,
  output logic               q_Spawn,
  output logic               q_Check,
  output logic               q_Win,
  output logic               q_Lose,
  output logic [SCORE_W-1:0] score,
  output logic [15:0]        moves
);

  localparam int CELLS = N * N;
  localparam int CW    = $clog2(CELLS);
  localparam int IW    = (1 << EW) + $clog2(N);
  localparam int SW    = ((IW > SCORE_W) ? IW : SCORE_W) + 1;

  state_t          state;
  logic [EW-1:0]   board [N][N];
  logic [15:0]     lfsr;
  logic            armed, moved, spawn_first;
  logic [1:0]      dir;
  logic [AW-1:0]   line;
  logic [CW-1:0]   idx, cur;
  logic [AW-1:0]   cur_row, cur_col;
  logic [N*EW-1:0] line_in, line_out;
  logic            line_changed;
  logic [IW-1:0]   line_inc;
  logic [SW-1:0]   score_sum;
  logic            any_win, any_empty, any_pair, key;

  game2048_line_merge #(.N(N), .EW(EW)) u_line_merge (
    .line_in  (line_in),
    .line_out (line_out),
    .changed  (line_changed),
    .inc      (line_inc)
  );

  assign key       = up | down | left | right;
  assign score_sum = SW'(score) + SW'(line_inc);
  assign cur       = spawn_first ? CW'(lfsr % 16'(CELLS)) : idx;
  assign cur_row   = AW'(cur / CW'(N));
  assign cur_col   = AW'(cur % CW'(N));

  always_comb begin
    line_in = '0;
    for (int j = 0; j < N; j++) begin
      case (dir)
        DIR_LEFT:  line_in[j*EW +: EW] = board[line][j];
        DIR_RIGHT: line_in[j*EW +: EW] = board[line][N-1-j];
        DIR_UP:    line_in[j*EW +: EW] = board[j][line];
        default:   line_in[j*EW +: EW] = board[N-1-j][line];
      endcase
    end
  end

  always_comb begin
    any_win = 1'b0;
    any_empty = 1'b0;
    any_pair = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (board[r][c] >= EW'(WIN_EXP)) any_win = 1'b1;
        if (board[r][c] == '0) any_empty = 1'b1;
      end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N-1; c++)
        if (board[r][c] == board[r][c+1]) any_pair = 1'b1;
    for (int r = 0; r < N-1; r++)
      for (int c = 0; c < N; c++)
        if (board[r][c] == board[r+1][c]) any_pair = 1'b1;
  end

  always_comb begin
    rd_tile = '0;
    if (int'(rd_row) < N && int'(rd_col) < N) rd_tile = board[rd_row][rd_col];
  end

  assign q_I     = (state == S_I);
  assign q_Wait  = (state == S_WAIT);
  assign q_Move  = (state == S_MOVE);
  assign q_Spawn = (state == S_SPAWN);
  assign q_Check = (state == S_CHECK);
  assign q_Win   = (state == S_WIN);
  assign q_Lose  = (state == S_LOSE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_I;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) board[r][c] <= '0;
      score       <= '0;
      moves       <= '0;
      lfsr        <= LFSR_SEED;
      armed       <= 1'b0;
      dir         <= DIR_UP;
      line        <= '0;
      moved       <= 1'b0;
      idx         <= '0;
      spawn_first <= 1'b1;
    end else begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      case (state)
        S_I: begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) board[r][c] <= '0;
          spawn_first <= 1'b1;
          state       <= S_SPAWN;
        end
        S_WAIT: begin
          if (!key) armed <= 1'b1;
          if (armed && key) begin
            dir   <= up ? DIR_UP : down ? DIR_DOWN : left ? DIR_LEFT : DIR_RIGHT;
            armed <= 1'b0;
            line  <= '0;
            moved <= 1'b0;
            state <= S_MOVE;
          end else if (wr_en && int'(wr_row) < N && int'(wr_col) < N) begin
            board[wr_row][wr_col] <= wr_tile;
          end
        end
        S_MOVE: begin
          for (int j = 0; j < N; j++) begin
            case (dir)
              DIR_LEFT:  board[line][j]     <= line_out[j*EW +: EW];
              DIR_RIGHT: board[line][N-1-j] <= line_out[j*EW +: EW];
              DIR_UP:    board[j][line]     <= line_out[j*EW +: EW];
              default:   board[N-1-j][line] <= line_out[j*EW +: EW];
            endcase
          end
          score <= (|score_sum[SW-1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
          moved <= moved | line_changed;
          if (line == AW'(N-1)) begin
            if (moved | line_changed) begin
              moves       <= moves + 16'd1;
              spawn_first <= 1'b1;
              state       <= S_SPAWN;
            end else begin
              state <= S_WAIT;
            end
          end else begin
            line <= line + AW'(1);
          end
        end
        S_SPAWN: begin
          spawn_first <= 1'b0;
          if (board[cur_row][cur_col] == '0) begin
            board[cur_row][cur_col] <= (lfsr[2:0] == 3'd0) ? EW'(2) : EW'(1);
            state <= S_CHECK;
          end else begin
            idx <= (cur == CW'(CELLS-1)) ? '0 : cur + CW'(1);
          end
        end
        S_CHECK: begin
          if (any_win)                      state <= S_WIN;
          else if (!any_empty && !any_pair) state <= S_LOSE;
          else                              state <= S_WAIT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/game2048_engine.md
# game2048_engine

Parametrised N×N 2048 game engine that replaces the fixed 4×4 controller. It holds the board as per-cell exponents and performs moves one line per cycle with correct single-merge-per-move semantics. After any move that changes the board, it spawns a pseudo-random tile, then checks for win or loss. It sits between the debounced direction-button inputs and the VGA renderer, which reads tiles through a read port.

## Interface

- `N`, 4: board dimension, legal range 2..8
- `EW`, 4: exponent width; cell value 0 = empty, k = tile 2^k
- `WIN_EXP`, 11: winning exponent; must satisfy WIN_EXP ≤ 2^EW−1
- `SCORE_W`, 20: score counter width
- `LFSR_SEED`, 16'hACE1: 16-bit LFSR reset value; must be nonzero

Ports:

- `Clk` in 1: clock
- `Reset` in 1: synchronous, active-high
- `up`, `down`, `left`, `right` in 1 each: level direction requests
- `wr_en` in 1: bench/debug cell write, honoured only in WAIT
- `wr_row`, `wr_col` in clog2(N): write address
- `wr_tile` in EW: write data
- `rd_row`, `rd_col` in clog2(N): read address
- `rd_tile` out EW: combinational board[rd_row][rd_col]; 0 if the address is out of range
- `q_I`, `q_Wait`, `q_Move`, `q_Spawn`, `q_Check`, `q_Win`, `q_Lose` out 1 each: one-hot state
- `score` out SCORE_W: accumulated merge score
- `moves` out 16: count of effective moves

## Operation

- **Reset:** state = I; all cells 0; score = 0; moves = 0; LFSR = LFSR_SEED; armed = 0; dir = 0. Only `q_I` is high.
- **LFSR:** 16-bit maximal Fibonacci LFSR, taps 16,14,13,11. It advances every non-reset cycle, so spawn placement depends on player timing.
- **I:** clear board, go to SPAWN.
- **WAIT:**
  - `wr_en` writes the addressed cell.
  - armed ← 1 whenever all four directions are low.
  - If armed and any direction is high: latch dir with priority up > down > left > right, clear armed, set line = 0, clear the moved flag, go to MOVE. `wr_en` is ignored in that same cycle.
- **MOVE:** processes one line per cycle, for line = 0..N−1.
  - Line orientation, element 0 is the destination end:
    - LEFT: row `line`, cols 0→N−1
    - RIGHT: row `line`, cols N−1→0
    - UP: col `line`, rows 0→N−1
    - DOWN: col `line`, rows N−1→0
  - Line transform:
    - Compact nonzero cells toward element 0.
    - Equal adjacent pairs merge into one cell of exponent e+1, scanning from element 0.
    - Each cell merges at most once. Example: [1,1,2,0] → [2,2,0,0], not [3,0,0,0].
    - Each merge adds 2^(e+1) to score, saturating at all-ones.
  - moved |= (line output ≠ line input). The line is written back in the same cycle.
  - After line N−1: if moved, moves++ (wraps) and go to SPAWN; otherwise return to WAIT with no spawn.
- **SPAWN:**
  - On entry, start index = LFSR mod N² (row-major).
  - Test one cell per cycle, incrementing with wrap at N².
  - At the first empty cell, write exponent 2 if LFSR[2:0] = 0, else exponent 1, then go to CHECK.
  - An effective move always leaves at least one empty cell, so the search ends within N² cycles. The SPAWN entered from I also finds a cell immediately.
- **CHECK** (single cycle, combinational over the whole board):
  - WIN if any cell ≥ WIN_EXP.
  - Else LOSE if there is no empty cell and no horizontally or vertically adjacent equal pair.
  - Else WAIT.
- **WIN / LOSE:** terminal. Board, score and moves are frozen. Direction and `wr_en` inputs are ignored until Reset.

## Timing

- Reset takes effect at the first Clk edge where it is high, in any state, including mid-MOVE or mid-SPAWN.
- After reset: 1 cycle in I, 1..N² cycles in SPAWN, then 1 cycle in CHECK, then WAIT.
- Effective move, from the WAIT cycle that accepts the request to WAIT again: N cycles MOVE + 1..N² cycles SPAWN + 1 cycle CHECK.
- Ineffective move: N cycles MOVE, then WAIT; score, moves and board are unchanged.
- A held key produces exactly one move; all directions must be low for ≥ 1 WAIT cycle to re-arm.
- `score` and `moves` update at the clock edge that writes the line or completes MOVE. `rd_tile` reflects board writes on the following cycle.

## Structure

- Package `game2048_pkg`:
  - state encoding localparams: I, WAIT, MOVE, SPAWN, CHECK, WIN, LOSE
  - direction codes
  - LFSR tap constant
- Sub-module `game2048_line_merge`: combinational, parameters N and EW.
  - Inputs: line in.
  - Outputs: line out, changed flag, score increment.
  - One instance, time-multiplexed across lines.

## Test plan

- **Reset/spawn:** Reset, then release → one cycle with `q_I` = 1; exactly one cell of exponent 1 or 2; `q_Wait` within N²+2 cycles; score = 0; moves = 0.
- **Single merge:** Write row 0 = [1,1,2,0], rest of board empty; press left → row 0 = [2,2,x,x] before spawn; score += 4; moves = 1.
- **Quad row:** Row 0 = [1,1,1,1]; left → [2,2,0,0] plus spawn; score += 8.
- **No-op move:** Only row 0 = [1,2,3,4], rest empty; press left → back in WAIT after N cycles; no spawn; board, score and moves unchanged.
- **Hold/arming:** Hold right across 200 cycles → exactly one move; release one cycle and press again → second move.
- **Win and lose:**
  - Win: (0,0) = (0,1) = 10; left → `q_Win`; further inputs ignored.
  - Lose: rows [0,4,3,4], [3,4,3,4], [4,3,4,3], [3,4,3,4]; left → spawn at (0,3), then `q_Lose`.
